// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for a non-pipelined RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB.
// Optional retired-instruction counter enabled by defining RETIRE_COUNT_EN.
module rv_multicycle_ctrl #(
    parameter int ALU_ADDR_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_b5,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  pc_sel,
    output logic                  reg_we,
    output logic [1:0]            wb_sel,
    output logic                  alu_src_b,
    output logic [ALU_ADDR_W-1:0] alu_addr,
    output logic [2:0]            state,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retire_cnt
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t                r_state, w_next;
    logic [6:0]            r_op;
    logic [ALU_ADDR_W-1:0] r_alu_addr;
    logic [3:0]            w_alu4;
    logic [ALU_ADDR_W-1:0] w_alu_addr;
    logic                  w_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_alu_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op       <= opcode;
            if (r_state == S_EXEC)   r_alu_addr <= w_alu_addr;
        end
    end

    // ALU ROM address and branch outcome; IR fields stay stable until the next FETCH.
    always_comb begin
        w_alu4  = 4'b0000;
        w_taken = 1'b0;
        case (r_op)
            OP_R:   w_alu4 = {funct7_b5, funct3};
            OP_IMM: w_alu4 = {funct7_b5 & (funct3 == 3'b101), funct3};
            OP_BRANCH: begin
                case (funct3)
                    3'b000:         begin w_alu4 = 4'b1000; w_taken =  alu_zero; end
                    3'b001:         begin w_alu4 = 4'b1000; w_taken = !alu_zero; end
                    3'b100, 3'b110: begin w_alu4 = {3'b001, funct3[1]}; w_taken = !alu_zero; end
                    3'b101, 3'b111: begin w_alu4 = {3'b001, funct3[1]}; w_taken =  alu_zero; end
                    default:        w_alu4 = 4'b1000;
                endcase
            end
            default: w_alu4 = 4'b0000;
        endcase
        w_alu_addr = ALU_ADDR_W'(w_alu4);
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        alu_src_b = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: w_next = S_EXEC;
                    OP_LUI:  w_next = S_WB;
                    default: w_next = S_TRAP;
                endcase
            end
            S_EXEC: begin
                alu_src_b = (r_op == OP_IMM) || (r_op == OP_LOAD) || (r_op == OP_STORE);
                case (r_op)
                    OP_BRANCH: begin
                        pc_we  = w_taken;
                        pc_sel = w_taken;
                        w_next = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                        w_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    default:           w_next = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_op == OP_STORE);
                if (mem_ready) w_next = (r_op == OP_LOAD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_we = 1'b1;
                case (r_op)
                    OP_LOAD: wb_sel = 2'b01;
                    OP_JAL:  wb_sel = 2'b10;
                    OP_LUI:  wb_sel = 2'b11;
                    default: wb_sel = 2'b00;
                endcase
                w_next = S_FETCH;
            end
            S_TRAP:  illegal = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    // Live value during EXEC, held afterwards; forced quiet while trapped.
    assign alu_addr = (r_state == S_EXEC) ? w_alu_addr :
                      (r_state == S_TRAP) ? '0 : r_alu_addr;
    assign state    = r_state;

`ifdef RETIRE_COUNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_retire_cnt;

    assign w_retire = (r_state == S_WB) ||
                      ((r_state == S_MEM)  && mem_ready && (r_op == OP_STORE)) ||
                      ((r_state == S_EXEC) && (r_op == OP_BRANCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_retire_cnt <= '0;
        else if (w_retire) r_retire_cnt <= r_retire_cnt + 1'b1;
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: state sequencing, control outputs, trap and retire count.
module tb_rv_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5, alu_zero, mem_ready;
    logic        mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, alu_src_b, illegal;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_addr;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef RETIRE_COUNT_EN
    localparam logic [31:0] EXP_RETIRE = 32'd5;
`else
    localparam logic [31:0] EXP_RETIRE = 32'd0;
`endif

    rv_multicycle_ctrl #(.ALU_ADDR_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .alu_addr(alu_addr), .state(state), .illegal(illegal),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        opcode = op; funct3 = f3; funct7_b5 = f7; alu_zero = z;
        #1;
    endtask

    // Runs one instruction from a FETCH check point until FETCH returns (bounded).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        int n;
        set_instr(op, f3, f7, z);
        n = 0;
        do begin step(); n++; end while (state !== 3'd1 && n < 20);
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++; $display("FAIL run_instr_timeout op=%b: state=%0d required=1", op, state);
        end
    endtask

    task automatic test_reset();
        logic [2:0] exp_s [5];
        exp_s = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        rst_n = 1'b0; mem_ready = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        repeat (3) step();
        n_chk++;
        if ({mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src_b, alu_addr,
             state, illegal, retire_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero, state=%0d mem_req=%b", state, mem_req);
        end
        rst_n = 1'b1; #1;
        n_chk++;
        if ({state, mem_req} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL idle_after_release: state=%0d mem_req=%b required 0/0", state, mem_req);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if ({state, mem_req} !== {exp_s[i], exp_s[i] == 3'd1}) begin
                n_fail++; $display("FAIL reset_seq[%0d]: state=%0d mem_req=%b required state=%0d", i, state, mem_req, exp_s[i]);
            end
        end
    endtask

    task automatic test_rtype_sub();
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        n_chk++;
        if ({state, mem_req, ir_we, pc_we, pc_sel} !== {3'd1, 4'b1110}) begin
            n_fail++; $display("FAIL sub_fetch: got %b required %b", {state, mem_req, ir_we, pc_we, pc_sel}, {3'd1, 4'b1110});
        end
        step();
        n_chk++;
        if ({state, mem_req, ir_we, pc_we, reg_we} !== {3'd2, 4'b0000}) begin
            n_fail++; $display("FAIL sub_decode: got %b", {state, mem_req, ir_we, pc_we, reg_we});
        end
        step();
        n_chk++;
        if ({state, alu_addr, alu_src_b, pc_we, reg_we} !== {3'd3, 4'b1000, 3'b000}) begin
            n_fail++; $display("FAIL sub_exec: state=%0d alu_addr=%b src_b=%b required 3/1000/0", state, alu_addr, alu_src_b);
        end
        step();
        n_chk++;
        if ({state, reg_we, wb_sel, alu_addr} !== {3'd5, 1'b1, 2'b00, 4'b1000}) begin
            n_fail++; $display("FAIL sub_wb: state=%0d reg_we=%b wb_sel=%b alu_addr=%b", state, reg_we, wb_sel, alu_addr);
        end
        step();
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++; $display("FAIL sub_latency: state=%0d required 1 after 4 cycles", state);
        end
    endtask

    task automatic test_load_wait();
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step(); step();
        n_chk++;
        if ({state, alu_addr, alu_src_b} !== {3'd3, 4'b0000, 1'b1}) begin
            n_fail++; $display("FAIL load_exec: state=%0d alu_addr=%b src_b=%b", state, alu_addr, alu_src_b);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) mem_ready = 1'b1;
            #1;
            n_chk++;
            if ({state, mem_req, mem_we, reg_we} !== {3'd4, 3'b100}) begin
                n_fail++; $display("FAIL load_mem[%0d]: state=%0d mem_req=%b mem_we=%b", i, state, mem_req, mem_we);
            end
        end
        step();
        n_chk++;
        if ({state, reg_we, wb_sel} !== {3'd5, 1'b1, 2'b01}) begin
            n_fail++; $display("FAIL load_wb: state=%0d reg_we=%b wb_sel=%b required 5/1/01", state, reg_we, wb_sel);
        end
        step();
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++; $display("FAIL load_latency: state=%0d required 1 after 8 cycles", state);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3  [5];
        logic       z   [5];
        logic [3:0] ea  [5];
        logic       tk  [5];
        f3 = '{3'b001, 3'b001, 3'b100, 3'b111, 3'b101};
        z  = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0};
        ea = '{4'b1000, 4'b1000, 4'b0010, 4'b0011, 4'b0010};
        tk = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0};
        for (int i = 0; i < 5; i++) begin
            set_instr(7'b1100011, f3[i], 1'b0, z[i]);
            step(); step();
            n_chk++;
            if ({state, alu_addr, pc_we, pc_sel, alu_src_b} !== {3'd3, ea[i], tk[i], tk[i], 1'b0}) begin
                n_fail++; $display("FAIL branch[%0d]: state=%0d alu_addr=%b pc_we=%b pc_sel=%b required %b/%b",
                                   i, state, alu_addr, pc_we, pc_sel, ea[i], tk[i]);
            end
            step();
            n_chk++;
            if (state !== 3'd1) begin
                n_fail++; $display("FAIL branch_latency[%0d]: state=%0d required 1", i, state);
            end
        end
    endtask

    task automatic test_ialu();
        set_instr(7'b0010011, 3'b101, 1'b1, 1'b0);
        step(); step();
        n_chk++;
        if ({alu_addr, alu_src_b} !== {4'b1101, 1'b1}) begin
            n_fail++; $display("FAIL srai_exec: alu_addr=%b src_b=%b required 1101/1", alu_addr, alu_src_b);
        end
        step();
        n_chk++;
        if ({state, reg_we, wb_sel, alu_addr} !== {3'd5, 1'b1, 2'b00, 4'b1101}) begin
            n_fail++; $display("FAIL srai_wb_hold: state=%0d wb_sel=%b alu_addr=%b", state, wb_sel, alu_addr);
        end
        step();
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        step(); step();
        n_chk++;
        if ({alu_addr, alu_src_b} !== {4'b0000, 1'b1}) begin
            n_fail++; $display("FAIL addi_f7mask: alu_addr=%b required 0000", alu_addr);
        end
        step(); step();
    endtask

    task automatic test_store();
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        step(); step();
        n_chk++;
        if ({state, alu_addr, alu_src_b} !== {3'd3, 4'b0000, 1'b1}) begin
            n_fail++; $display("FAIL store_exec: state=%0d alu_addr=%b src_b=%b", state, alu_addr, alu_src_b);
        end
        step();
        n_chk++;
        if ({state, mem_req, mem_we, reg_we} !== {3'd4, 3'b110}) begin
            n_fail++; $display("FAIL store_mem: state=%0d mem_req=%b mem_we=%b", state, mem_req, mem_we);
        end
        step();
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++; $display("FAIL store_latency: state=%0d required 1", state);
        end
    endtask

    task automatic test_jal();
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        step(); step();
        n_chk++;
        if ({state, pc_we, pc_sel, alu_addr, alu_src_b} !== {3'd3, 2'b11, 4'b0000, 1'b0}) begin
            n_fail++; $display("FAIL jal_exec: state=%0d pc_we=%b pc_sel=%b alu_addr=%b", state, pc_we, pc_sel, alu_addr);
        end
        step();
        n_chk++;
        if ({state, reg_we, wb_sel} !== {3'd5, 1'b1, 2'b10}) begin
            n_fail++; $display("FAIL jal_wb: state=%0d wb_sel=%b required 10", state, wb_sel);
        end
        step();
    endtask

    task automatic test_lui();
        set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
        step(); step();
        n_chk++;
        if ({state, reg_we, wb_sel} !== {3'd5, 1'b1, 2'b11}) begin
            n_fail++; $display("FAIL lui_wb: state=%0d reg_we=%b wb_sel=%b required 5/1/11", state, reg_we, wb_sel);
        end
        step();
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++; $display("FAIL lui_latency: state=%0d required 1", state);
        end
    endtask

    task automatic test_retire();
        rst_n = 1'b0; #1;
        step(); rst_n = 1'b1;
        step();
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
        n_chk++;
        if (retire_cnt !== EXP_RETIRE) begin
            n_fail++; $display("FAIL retire_count: got %0d required %0d", retire_cnt, EXP_RETIRE);
        end
        mem_ready = 1'b0;
        step();
        n_chk++;
        if ({state, mem_req} !== {3'd1, 1'b1}) begin
            n_fail++; $display("FAIL fetch_hold: state=%0d mem_req=%b required 1/1", state, mem_req);
        end
        rst_n = 1'b0; #1;
        n_chk++;
        if ({state, mem_req, retire_cnt} !== {3'd0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL reset_mid_fetch: state=%0d mem_req=%b retire_cnt=%0d", state, mem_req, retire_cnt);
        end
        step(); rst_n = 1'b1; mem_ready = 1'b1;
        step();
    endtask

    task automatic test_trap();
        set_instr(7'b1110011, 3'b000, 1'b0, 1'b0);
        step();
        n_chk++;
        if ({state, illegal} !== {3'd2, 1'b0}) begin
            n_fail++; $display("FAIL trap_decode: state=%0d illegal=%b", state, illegal);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            mem_ready = i[0]; #1;
            n_chk++;
            if ({state, illegal, mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src_b, alu_addr}
                !== {3'd6, 1'b1, 13'd0}) begin
                n_fail++; $display("FAIL trap_sticky[%0d]: state=%0d illegal=%b mem_req=%b pc_we=%b",
                                   i, state, illegal, mem_req, pc_we);
            end
        end
        rst_n = 1'b0; #1;
        n_chk++;
        if ({state, illegal} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL trap_reset: state=%0d illegal=%b required 0/0", state, illegal);
        end
        step(); rst_n = 1'b1; mem_ready = 1'b1;
        step();
        n_chk++;
        if ({state, illegal} !== {3'd1, 1'b0}) begin
            n_fail++; $display("FAIL trap_recover: state=%0d illegal=%b required 1/0", state, illegal);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_load_wait();
        test_branch();
        test_ialu();
        test_store();
        test_jal();
        test_lui();
        test_retire();
        test_trap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the non-pipelined RV32I core.
- Sequences one shared ALU, a single instruction/data memory port, PC and IR through the FETCH/DECODE/EXEC/MEM/WB phases.
- Produces the 4-bit address driven into the ALU control ROM, so operation selection stays table-based.
- Sits between the instruction register fields and the datapath enables.

Parameters:
- ALU_ADDR_W, 4, width of ALU control ROM address.
- CNT_W, 32, width of the retired-instruction counter (optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_b5  in  1  IR[30].
- alu_zero  in  1  ALU result==0 flag.
- mem_ready  in  1  memory access complete this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store when 1.
- ir_we  out  1  latch fetched word into IR.
- pc_we  out  1  update PC.
- pc_sel  out  1  0: PC+4, 1: branch/jump target.
- reg_we  out  1  register file write.
- wb_sel  out  2  00: ALU, 01: load data, 10: PC+4, 11: immediate.
- alu_src_b  out  1  0: rs2, 1: immediate.
- alu_addr  out  ALU_ADDR_W  ALU control ROM address.
- state  out  3  current FSM state (debug).
- illegal  out  1  unsupported opcode trapped.
- retire_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. Every output is 0, including retire_cnt. Reset asserted mid-access aborts it; mem_req drops in the same cycle.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: outputs 0; next state FETCH unconditionally.
- FETCH:
  - mem_req=1, mem_we=0.
  - Holds until mem_ready=1. On that cycle ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
- DECODE: opcode latched internally; no outputs asserted.
  - Next = EXEC for 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL).
  - Next = WB for 0110111 (LUI).
  - Any other opcode → TRAP.
- EXEC, alu_addr rules:
  - R: {funct7_b5, funct3}.
  - I-ALU: {funct7_b5 & (funct3==3'b101), funct3}.
  - LOAD/STORE/JAL: 4'b0000 (ADD).
  - BRANCH: BEQ/BNE → 4'b1000 (SUB); BLT/BGE → 4'b0010 (SLT); BLTU/BGEU → 4'b0011 (SLTU).
- EXEC, operand select: alu_src_b=1 for I-ALU/LOAD/STORE; otherwise 0.
- EXEC, branch decision: taken when BEQ&zero, BNE&!zero, BLT/BLTU&!zero, or BGE/BGEU&zero. Taken → pc_we=1, pc_sel=1.
- EXEC, JAL: pc_we=1, pc_sel=1.
- EXEC, next state: BRANCH → FETCH; LOAD/STORE → MEM; others → WB.
- MEM:
  - mem_req=1; mem_we=1 for STORE.
  - Holds until mem_ready. Then LOAD → WB, STORE → FETCH.
- WB: reg_we=1 for exactly one cycle, then FETCH.
  - wb_sel: LOAD=01, JAL=10, LUI=11, otherwise 00.
- TRAP: illegal=1, all other outputs 0. Sticky until reset.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - 3 cycles: BRANCH, LUI.
  - 4 cycles: R, I, STORE, JAL.
  - 5 cycles: LOAD.
  - Each wait cycle adds 1.
- alu_addr holds its last EXEC value outside EXEC. It is 0 after reset.
- mem_req never deasserts before mem_ready while out of reset. mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- Defined: retire_cnt increments by 1 on the last cycle of each instruction. That cycle is the WB cycle, the STORE MEM cycle with mem_ready, or the BRANCH EXEC cycle.
  - Wraps from 2^CNT_W-1 to 0.
  - Does not count in TRAP.
- Undefined: retire_cnt tied to 0 and no counter flops.

Test Plan:
- Reset release, mem_ready=1 permanently → state sequence IDLE, FETCH, DECODE. mem_req=1 only in FETCH; all outputs 0 during reset.
- R-type SUB (opcode 0110011, funct3 000, funct7_b5 1), zero-wait → alu_addr=4'b1000 in EXEC; reg_we=1, wb_sel=00 in WB; 4 cycles FETCH-to-FETCH.
- LOAD with mem_ready low for 3 MEM cycles → mem_req held high for 4 MEM cycles; WB has wb_sel=01; total 8 cycles.
- BNE with alu_zero=0 → EXEC has alu_addr=4'b1000, pc_we=1, pc_sel=1. Repeat with alu_zero=1 → pc_we=0.
- Opcode 1110011 → TRAP, illegal=1 sticky for 20 cycles; rst_n pulse low → IDLE, illegal=0.
- RETIRE_COUNT_EN defined, 5 mixed instructions (R, LOAD, STORE, BRANCH, LUI) → retire_cnt=5. Assert rst_n low mid-FETCH → retire_cnt=0 immediately.
